msk_share_encoder: RTL and testbench

Stream-side masking encoder: accepts unmasked W-bit words and fresh randomness over two valid/ready channels, and emits d-share Boolean sharings into the masked datapath, where they feed gadgets such as the HPC-family AND gadgets. It is the producer end of the sharing interface that the gadgets consume. It holds a 2-entry output buffer so it sustains one sharing per cycle without a combinational path from out_ready back to the input channels. Plaintext is never registered: only shares are stored.

---
 rtl/msk_share_encoder_pkg.sv | 20 ++
 rtl/msk_share_encoder_if.sv | 29 ++
 rtl/msk_share_encoder_fifo.sv | 71 +++++++
 rtl/msk_share_encoder.sv | 63 ++++++
 tb/tb_msk_share_encoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/msk_share_encoder_pkg.sv
// Shared types and index helpers for the masking encoder slice.
package msk_enc_pkg;

  // Width of the randomness bus: one fresh W-bit mask per non-final share.
  function automatic int rnd_width(input int d, input int w);
    return (d - 1) * w;
  endfunction

  // Position of share j of bit i in the per-bit interleaved sharing.
  function automatic int shidx(input int i, input int j, input int d);
    return i * d + j;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/msk_share_encoder_if.sv
// Handshake bundle between the stream producer, the encoder and the masked datapath.
interface msk_share_encoder_if #(
  parameter int d = 2,
  parameter int W = 8
);
  import msk_enc_pkg::*;

  logic [W-1:0]                in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [rnd_width(d, W)-1:0]  rnd;
  logic                        rnd_valid;
  logic                        rnd_ready;
  logic [d*W-1:0]              out_shares;
  logic                        out_valid;
  logic                        out_ready;
  logic                        rnd_starve;
  logic                        starve_clr;

  modport master (
    output in_data, in_valid, rnd, rnd_valid, out_ready, starve_clr,
    input  in_ready, rnd_ready, out_shares, out_valid, rnd_starve
  );

  modport slave (
    input  in_data, in_valid, rnd, rnd_valid, out_ready, starve_clr,
    output in_ready, rnd_ready, out_shares, out_valid, rnd_starve
  );
endinterface

// File: rtl/msk_share_encoder_fifo.sv
// Two-entry valid/ready buffer; head entry drives the output, vacated entries are zeroed.
module msk_skid_fifo2
  import msk_enc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          space,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  input  logic          dready
);
  fifo_state_t   state_q, state_d;
  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic          pop;

  assign pop    = dvalid & dready;
  assign dvalid = (state_q != EMPTY);
  assign space  = (state_q != FULL);
  assign dout   = head_q;

  // Occupancy transitions; freed slots are cleared so no stale share lingers.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        head_d  = din;
        state_d = ONE;
      end
      ONE: begin
        if (push && !pop) begin
          tail_d  = din;
          state_d = FULL;
        end else if (push && pop) begin
          head_d = din;
        end else if (pop) begin
          head_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        head_d  = tail_q;
        tail_d  = '0;
        state_d = ONE;
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  // State and storage registers; reset empties the buffer and wipes both slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
endmodule

// File: rtl/msk_share_encoder.sv
// Masking encoder: splits each word into d Boolean shares and buffers the sharing.
module msk_share_encoder
  import msk_enc_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst_n,
  msk_share_encoder_if.slave bus
);
  logic                  space;
  logic                  fire;
  logic [d-1:0][W-1:0]   share;
  logic [d*W-1:0]        share_il;
  logic                  rnd_starve_q, rnd_starve_d;

  // Word and randomness are taken together or not at all; ready never sees out_ready.
  assign fire          = bus.in_valid & bus.rnd_valid & space;
  assign bus.in_ready  = fire;
  assign bus.rnd_ready = fire;
  assign bus.rnd_starve = rnd_starve_q;

  // Shares 0..d-2 are the masks; the last share folds all masks into the plaintext.
  always_comb begin
    share      = '0;
    share[d-1] = bus.in_data;
    for (int j = 0; j < d - 1; j++) begin
      share[j]   = bus.rnd[j*W +: W];
      share[d-1] = share[d-1] ^ bus.rnd[j*W +: W];
    end
  end

  // Interleave so the d shares of each bit sit side by side for the gadgets.
  always_comb begin
    share_il = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < d; j++)
        share_il[shidx(i, j, d)] = share[j][i];
  end

  msk_skid_fifo2 #(.DW(d*W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fire),
    .din    (share_il),
    .space  (space),
    .dout   (bus.out_shares),
    .dvalid (bus.out_valid),
    .dready (bus.out_ready)
  );

  // Sticky starvation flag; a fresh starve event outranks a same-cycle clear.
  always_comb begin
    rnd_starve_d = (bus.in_valid & ~bus.rnd_valid & space) | (rnd_starve_q & ~bus.starve_clr);
  end

  // Starve flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_starve_q <= 1'b0;
    else        rnd_starve_q <= rnd_starve_d;
  end
endmodule

// File: tb/tb_msk_share_encoder.sv
// Bench for msk_share_encoder: a d=2 and a d=3 instance checked against a queue model.
module tb_msk_share_encoder;
  logic clk, rst_n;

  msk_share_encoder_if #(.d(2), .W(8)) bus0 ();
  msk_share_encoder_if #(.d(3), .W(8)) bus1 ();

  msk_share_encoder #(.d(2), .W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  msk_share_encoder #(.d(3), .W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus and observation, indexed by instance (0: d=2, 1: d=3).
  logic        iv[2], rv[2], ordy[2], sclr[2];
  logic [7:0]  idata[2];
  logic [15:0] rnd_a[2];
  logic        ov[2], ir[2], rr[2], st[2];
  logic [23:0] osh[2];

  assign bus0.in_data = idata[0];  assign bus1.in_data = idata[1];
  assign bus0.in_valid = iv[0];    assign bus1.in_valid = iv[1];
  assign bus0.rnd = rnd_a[0][7:0]; assign bus1.rnd = rnd_a[1];
  assign bus0.rnd_valid = rv[0];   assign bus1.rnd_valid = rv[1];
  assign bus0.out_ready = ordy[0]; assign bus1.out_ready = ordy[1];
  assign bus0.starve_clr = sclr[0]; assign bus1.starve_clr = sclr[1];
  assign ov[0] = bus0.out_valid;   assign ov[1] = bus1.out_valid;
  assign ir[0] = bus0.in_ready;    assign ir[1] = bus1.in_ready;
  assign rr[0] = bus0.rnd_ready;   assign rr[1] = bus1.rnd_ready;
  assign st[0] = bus0.rnd_starve;  assign st[1] = bus1.rnd_starve;
  assign osh[0] = {8'h00, bus0.out_shares};
  assign osh[1] = bus1.out_shares;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Share j of an interleaved sharing: bit i lives at i*dd+j.
  function automatic logic [7:0] get_share(input logic [23:0] v, input int dd, input int j);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i*dd + j];
    return r;
  endfunction

  // Recombined plaintext: XOR of all shares of each bit.
  function automatic logic [7:0] unmask(input logic [23:0] v, input int dd);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < dd; j++) r[i] = r[i] ^ v[i*dd + j];
    return r;
  endfunction

  // Model: ordered list of pending (word, masks) pairs, at most two deep.
  logic [7:0]  mdat[2][2];
  logic [15:0] mrnd[2][2];
  int          mcnt[2];
  logic        mst[2];
  int          pops[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mst[k] = 1'b0; pops[k] = 0;
    end
  end

  // Compare process: check every instance against the model on each falling edge,
  // then advance the model with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   dd;
      logic fire_m, set_m;
      dd = (k == 0) ? 2 : 3;
      if (!rst_n) begin
        chk("rst_out_valid", ov[k], 0);
        chk("rst_out_shares", osh[k], 0);
        chk("rst_starve", st[k], 0);
        mcnt[k] = 0;
        mst[k]  = 1'b0;
      end else begin
        chk("out_valid", ov[k], mcnt[k] != 0);
        if (mcnt[k] != 0) begin
          for (int j = 0; j < dd - 1; j++)
            chk("share_mask", get_share(osh[k], dd, j), mrnd[k][0][j*8 +: 8]);
          chk("unmasked", unmask(osh[k], dd), mdat[k][0]);
        end else begin
          chk("empty_shares", osh[k], 0);
        end
        fire_m = iv[k] & rv[k] & (mcnt[k] < 2);
        set_m  = iv[k] & ~rv[k] & (mcnt[k] < 2);
        chk("in_ready", ir[k], fire_m);
        chk("rnd_ready", rr[k], fire_m);
        chk("rnd_starve", st[k], mst[k]);
        if (ov[k] && ordy[k]) pops[k]++;
        if (mcnt[k] != 0 && ordy[k]) begin
          mdat[k][0] = mdat[k][1];
          mrnd[k][0] = mrnd[k][1];
          mcnt[k]--;
        end
        if (fire_m) begin
          mdat[k][mcnt[k]] = idata[k];
          mrnd[k][mcnt[k]] = rnd_a[k];
          mcnt[k]++;
        end
        mst[k] = set_m | (mst[k] & ~sclr[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] held;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; rv[k] = 0; ordy[k] = 0; sclr[k] = 0; idata[k] = 0; rnd_a[k] = 0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("init_valid", ov[0], 0);
    chk("init_shares", osh[0], 0);
    chk("init_starve", st[0], 0);
    chk("init_in_ready", ir[0], 0);
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    cyc();

    // Basic d=2: 0xA5 masked with 0x3C gives shares 0x3C / 0x99, interleaved 0x87D2.
    iv[0] = 1; rv[0] = 1; idata[0] = 8'hA5; rnd_a[0] = 16'h003C; ordy[0] = 1;
    cyc();
    iv[0] = 0; rv[0] = 0;
    chk("basic_valid", ov[0], 1);
    chk("basic_layout", osh[0], 24'h0087D2);
    chk("basic_share0", get_share(osh[0], 2, 0), 8'h3C);
    chk("basic_share1", get_share(osh[0], 2, 1), 8'h99);
    chk("basic_xor", unmask(osh[0], 2), 8'hA5);
    repeat (2) cyc();

    // Atomicity: word without randomness is held back and flags starvation.
    iv[0] = 1; rv[0] = 0; idata[0] = 8'h5A; rnd_a[0] = 16'h0011;
    repeat (3) cyc();
    chk("starve_set", st[0], 1);
    chk("starve_in_ready", ir[0], 0);
    rv[0] = 1;
    cyc();
    iv[0] = 0; rv[0] = 0;
    chk("atomic_fire", ov[0], 1);
    chk("atomic_xor", unmask(osh[0], 2), 8'h5A);
    sclr[0] = 1;
    cyc();
    sclr[0] = 0;
    chk("starve_clr", st[0], 0);
    cyc();

    // Backpressure: fill both slots, stall, then drain in order.
    ordy[0] = 0;
    iv[0] = 1; rv[0] = 1; idata[0] = 8'h01; rnd_a[0] = 16'h0077;
    cyc();
    idata[0] = 8'h02; rnd_a[0] = 16'h00F0;
    cyc();
    idata[0] = 8'h03; rnd_a[0] = 16'h000E;
    #1;
    chk("full_in_ready", ir[0], 0);
    chk("full_rnd_ready", rr[0], 0);
    held = osh[0];
    repeat (2) cyc();
    chk("bp_stable", osh[0], held);
    chk("bp_head", unmask(osh[0], 2), 8'h01);
    ordy[0] = 1;
    #1;
    chk("drain_first", unmask(osh[0], 2), 8'h01);
    cyc();
    chk("drain_second", unmask(osh[0], 2), 8'h02);
    chk("third_accept", ir[0], 1);
    cyc();
    iv[0] = 0; rv[0] = 0;
    chk("drain_third", unmask(osh[0], 2), 8'h03);
    repeat (2) cyc();

    // Streaming: d=3 for 100 random words, d=2 sustained push/pop for 20.
    pops[0] = 0; pops[1] = 0;
    ordy[0] = 1; ordy[1] = 1;
    for (int n = 0; n < 100; n++) begin
      iv[1] = 1; rv[1] = 1;
      idata[1] = 8'($urandom); rnd_a[1] = 16'($urandom);
      iv[0] = (n < 20); rv[0] = (n < 20);
      idata[0] = 8'($urandom); rnd_a[0] = 16'($urandom);
      cyc();
      if (n > 0 && n < 20) chk("one_no_bubble", ov[0], 1);
    end
    iv[0] = 0; rv[0] = 0; iv[1] = 0; rv[1] = 0;
    repeat (3) cyc();
    chk("stream_d3_count", pops[1], 100);
    chk("stream_d2_count", pops[0], 20);

    // Reset mid-stream with both buffers full.
    ordy[0] = 0; ordy[1] = 0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1; rv[k] = 1; idata[k] = 8'(8'hC0 + n); rnd_a[k] = 16'h5AA5;
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin iv[k] = 0; rv[k] = 0; end
    chk("pre_rst_valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid0", ov[0], 0);
    chk("async_rst_shares0", osh[0], 0);
    chk("async_rst_valid1", ov[1], 0);
    chk("async_rst_shares1", osh[1], 0);
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    ordy[0] = 1; ordy[1] = 1;
    repeat (3) cyc();
    chk("post_rst_idle", ov[0] | ov[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
